// File: rtl/mc_main_cu_pkg.sv
// Shared definitions for the multicycle main control unit: opcodes, ALU/mux
// encodings, FSM state enumeration and the bundled control-word type.
package mc_main_cu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        BRANCH   = 4'd8,
        ADDI_EX  = 4'd9,
        ADDI_WB  = 4'd10,
        JUMP     = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational decode of the current FSM state into the datapath control word.
module mc_ctrl_decode
    import mc_main_cu_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        // NOTE: every field gets a default first so no path leaves a latch behind.
        ctrl = '0;
        unique case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = !is_legal_op(opcode);
            end
            MEMADR, ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            RTYPE_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            RTYPE_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_cu.sv
// Multicycle MIPS-style main control unit: state register and next-state logic,
// with the control word produced by mc_ctrl_decode.
module mc_main_cu
    import mc_main_cu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       illegal_op
);

    state_t state_q, state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignment so every flop sees pre-edge values.
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = MEMADR;
                else if (opcode == OP_RTYPE)                state_d = RTYPE_EX;
                else if (opcode == OP_BEQ)                  state_d = BRANCH;
                else if (opcode == OP_ADDI)                 state_d = ADDI_EX;
                else if (opcode == OP_J)                    state_d = JUMP;
                else                                        state_d = FETCH;
            end
            MEMADR:   state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    if (mem_ready) state_d = MEMWB;
            MEMWR:    if (mem_ready) state_d = FETCH;
            RTYPE_EX: state_d = RTYPE_WB;
            ADDI_EX:  state_d = ADDI_WB;
            MEMWB, RTYPE_WB, BRANCH, ADDI_WB, JUMP: state_d = FETCH;
            // Encodings 12..15 recover to FETCH on the next edge.
            default:  state_d = FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .opcode    (opcode),
        .ctrl      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign ALUOp       = ctrl.alu_op;
    assign illegal_op  = ctrl.illegal_op;

endmodule

// File: tb/tb_mc_main_cu.sv
// Scoreboard bench for mc_main_cu: each instruction expands into its step
// sequence, expected control words are queued and compared every cycle.
module tb_mc_main_cu;

    localparam logic [5:0] T_OP_R    = 6'b000000;
    localparam logic [5:0] T_OP_LW   = 6'b100011;
    localparam logic [5:0] T_OP_SW   = 6'b101011;
    localparam logic [5:0] T_OP_BEQ  = 6'b000100;
    localparam logic [5:0] T_OP_ADDI = 6'b001000;
    localparam logic [5:0] T_OP_J    = 6'b000010;

    typedef enum int {
        S_FETCH, S_DECODE, S_ILLEGAL, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_REX, S_RWB, S_BEQ, S_AEX, S_AWB, S_JMP
    } step_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       illegal;
    } obs_t;

    typedef struct {
        obs_t  v;
        string name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource, ALUOp;
    logic       illegal_op;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    mc_main_cu dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    function automatic bit legal(input logic [5:0] op);
        return op inside {T_OP_R, T_OP_LW, T_OP_SW, T_OP_BEQ, T_OP_ADDI, T_OP_J};
    endfunction

    // Control word each instruction step must present.
    function automatic obs_t step_out(input step_e s, input logic mr);
        obs_t o;
        o = '0;
        case (s)
            S_FETCH:   begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
            S_DECODE:  begin o.alu_src_b = 2'b11; end
            S_ILLEGAL: begin o.alu_src_b = 2'b11; o.illegal = 1; end
            S_MEMADR:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            S_MEMRD:   begin o.mem_read = 1; o.iord = 1; end
            S_MEMWB:   begin o.reg_write = 1; o.mem_to_reg = 1; end
            S_MEMWR:   begin o.mem_write = 1; o.iord = 1; end
            S_REX:     begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            S_RWB:     begin o.reg_write = 1; o.reg_dst = 1; end
            S_BEQ:     begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; end
            S_AEX:     begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            S_AWB:     begin o.reg_write = 1; end
            S_JMP:     begin o.pc_write = 1; o.pc_source = 2'b10; end
            default:   o = '0;
        endcase
        return o;
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %05h expected %05h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus its expected control word.
    task automatic cyc(input logic [5:0] op, input logic mr, input logic r, input step_e s);
        exp_t e;
        @(posedge clk);
        #1;
        opcode    = op;
        mem_ready = mr;
        rst       = r;
        e.v       = step_out(s, mr);
        e.name    = s.name();
        exp_q.push_back(e);
    endtask

    // Expands one instruction into its cycle sequence; abort asserts rst in MEMRD.
    task automatic issue(input logic [5:0] op, input int fstall, input int mstall, input bit abort);
        for (int i = 0; i < fstall; i++) cyc(6'($urandom), 1'b0, 1'b0, S_FETCH);
        cyc(6'($urandom), 1'b1, 1'b0, S_FETCH);
        if (!legal(op)) begin
            cyc(op, 1'($urandom), 1'b0, S_ILLEGAL);
            return;
        end
        cyc(op, 1'($urandom), 1'b0, S_DECODE);
        case (op)
            T_OP_LW: begin
                cyc(op, 1'($urandom), 1'b0, S_MEMADR);
                if (abort) begin
                    cyc(op, 1'($urandom), 1'b1, S_MEMRD);
                    return;
                end
                for (int i = 0; i < mstall; i++) cyc(op, 1'b0, 1'b0, S_MEMRD);
                cyc(op, 1'b1, 1'b0, S_MEMRD);
                cyc(op, 1'($urandom), 1'b0, S_MEMWB);
            end
            T_OP_SW: begin
                cyc(op, 1'($urandom), 1'b0, S_MEMADR);
                for (int i = 0; i < mstall; i++) cyc(op, 1'b0, 1'b0, S_MEMWR);
                cyc(op, 1'b1, 1'b0, S_MEMWR);
            end
            T_OP_R: begin
                cyc(op, 1'($urandom), 1'b0, S_REX);
                cyc(op, 1'($urandom), 1'b0, S_RWB);
            end
            T_OP_BEQ: cyc(op, 1'($urandom), 1'b0, S_BEQ);
            T_OP_ADDI: begin
                cyc(op, 1'($urandom), 1'b0, S_AEX);
                cyc(op, 1'($urandom), 1'b0, S_AWB);
            end
            default: cyc(op, 1'($urandom), 1'b0, S_JMP);
        endcase
    endtask

    // Monitor: one expected control word per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            obs_t a;
            e = exp_q.pop_front();
            a = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal_op};
            check(e.name, a, e.v);
            check("mem_rw_exclusive", {16'b0, MemRead & MemWrite}, 17'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        ops = '{T_OP_R, T_OP_LW, T_OP_SW, T_OP_BEQ, T_OP_ADDI, T_OP_J};

        // Held in reset: FETCH outputs, and mem_ready=1 must not advance the state.
        cyc(6'h23, 1'b0, 1'b1, S_FETCH);
        cyc(6'h23, 1'b1, 1'b1, S_FETCH);
        cyc(6'h00, 1'b1, 1'b1, S_FETCH);

        issue(T_OP_LW,   0, 0, 1'b0);
        issue(T_OP_R,    0, 0, 1'b0);
        issue(T_OP_BEQ,  0, 0, 1'b0);
        issue(T_OP_J,    0, 0, 1'b0);
        issue(T_OP_SW,   0, 3, 1'b0);
        issue(6'h3F,     0, 0, 1'b0);
        issue(T_OP_LW,   1, 2, 1'b1);
        issue(T_OP_ADDI, 2, 0, 1'b0);
        issue(T_OP_LW,   0, 3, 1'b1);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom);
                while (legal(op)) op = 6'($urandom);
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            issue(op, $urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 15) == 0));
        end

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_main_cu.md
MC_MAIN_CU -- requirements
Module: mc_main_cu

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-002 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port: opcode  input  6  instruction[31:26], sampled from the instruction register.
REQ-004 SHALL have port: mem_ready  input  1  memory handshake; access completes in a cycle with mem_ready=1.
REQ-005 SHALL have outputs, each 1 bit: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA.
REQ-006 SHALL have outputs ALUSrcB (2 bits) and PCSource (2 bits).
REQ-007 SHALL have output ALUOp (2 bits): 00 add, 01 sub, 10 R-type (func decoded downstream), 11 unused/never driven.
REQ-008 SHALL have output illegal_op (1 bit): one-cycle pulse on an unsupported opcode.

Function
REQ-009 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BRANCH, ADDI_EX, ADDI_WB, JUMP.
REQ-010 SHALL decode opcodes: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 001000 addi, 000010 j.
REQ-011 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, with IRWrite=PCWrite=mem_ready.
REQ-012 FETCH SHALL hold while mem_ready=0, then go to DECODE.
REQ-013 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
REQ-014 DECODE SHALL branch: lw/sw->MEMADR, R-type->RTYPE_EX, beq->BRANCH, addi->ADDI_EX, j->JUMP.
REQ-015 DECODE SHALL, on any other opcode, pulse illegal_op=1 for that cycle and return to FETCH.
REQ-016 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMRD for lw or MEMWR for sw.
REQ-017 MEMRD SHALL drive MemRead=1, IorD=1, hold while mem_ready=0, then go to MEMWB.
REQ-018 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-019 MEMWR SHALL drive MemWrite=1, IorD=1, hold while mem_ready=0, then go to FETCH.
REQ-020 RTYPE_EX SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to RTYPE_WB.
REQ-021 RTYPE_WB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0, then go to FETCH.
REQ-022 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then go to FETCH.
REQ-023 ADDI_EX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to ADDI_WB.
REQ-024 ADDI_WB SHALL drive RegWrite=1, RegDst=0, MemtoReg=0, then go to FETCH.
REQ-025 JUMP SHALL drive PCWrite=1, PCSource=10, then go to FETCH.
REQ-026 Every output not listed for a state SHALL be 0 in that state.
REQ-027 MemRead and MemWrite SHALL never be 1 in the same cycle.
REQ-028 An unreachable state encoding SHALL return to FETCH on the next edge with all outputs 0.
REQ-029 Instruction latencies SHALL be (mem_ready=1): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
REQ-030 Each cycle with mem_ready=0 in FETCH/MEMRD/MEMWR SHALL add exactly one cycle of latency.

Reset
REQ-031 rst=1 at a rising edge SHALL force state to FETCH, overriding any transition, including mid-instruction or mid-stall.
REQ-032 After reset, outputs SHALL equal the FETCH values of REQ-011; illegal_op=0; all others 0.

Structure
REQ-033 A shared package SHALL hold the opcode constants, ALUOp encodings (00/01/10) and the state enumeration.
REQ-034 A single sub-module, mc_ctrl_decode, SHALL hold the combinational state-to-output decode; next-state logic and the state register stay in mc_main_cu.

Verification
REQ-035 Test lw (100011) with mem_ready=1 -> sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 and MemtoReg=1 in cycle 5 only.
REQ-036 Test R-type (000000) -> ALUOp=10 in RTYPE_EX, then RegDst=1 and RegWrite=1; back in FETCH after 4 cycles.
REQ-037 Test beq (000100) -> ALUOp=01, PCWriteCond=1, PCSource=01 in cycle 3; also test j (000010) -> PCWrite=1, PCSource=10 in cycle 3.
REQ-038 Test sw with mem_ready=0 for 3 cycles in MEMWR -> MemWrite held 4 cycles and RegWrite never 1.
REQ-039 Test opcode 111111 -> illegal_op=1 for one cycle in DECODE, then FETCH.
REQ-040 Test rst=1 asserted during MEMRD -> next cycle in FETCH with REQ-011 outputs.
